// File: rtl/demux_stream4.sv
// 1-to-4 registered stream demultiplexer with per-channel output registers,
// valid/ready handshakes and saturating delivered-beat counters.
module demux_stream4 #(
  parameter int WIDTH = 2,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  input  logic             cnt_clr,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1,
  output logic [CNTW-1:0]  cnt2,
  output logic [CNTW-1:0]  cnt3
);

  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] data_q [4];
  logic [CNTW-1:0]  cnt_q  [4];
  logic [3:0]       valid_q;
  logic [3:0]       sel_oh;
  logic [3:0]       acc;
  logic [3:0]       dlv;
  logic             accept;

  always_comb begin
    sel_oh = '0;
    unique case (1'b1)
      (in_sel == 2'd0): sel_oh = 4'b0001;
      (in_sel == 2'd1): sel_oh = 4'b0010;
      (in_sel == 2'd2): sel_oh = 4'b0100;
      default:          sel_oh = 4'b1000;
    endcase
  end

  // A full slot can still take a beat when it is being drained this cycle.
  assign in_ready = ~valid_q[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;
  assign acc      = sel_oh & {4{accept}};
  assign dlv      = valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (acc[k]) begin
          data_q[k]  <= in_data;
          valid_q[k] <= 1'b1;
        end else if (dlv[k]) begin
          valid_q[k] <= 1'b0;
        end
        // Clear wins over a same-cycle delivery.
        if (cnt_clr)
          cnt_q[k] <= '0;
        else if (dlv[k] && cnt_q[k] != CNT_MAX)
          cnt_q[k] <= cnt_q[k] + CNT_ONE;
      end
    end
  end

  assign out_valid = valid_q;
  assign out0 = data_q[0];
  assign out1 = data_q[1];
  assign out2 = data_q[2];
  assign out3 = data_q[3];
  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_stream4.sv
// Self-checking bench for demux_stream4: directed scenarios plus a randomized
// run against a slot-occupancy reference model.
module tb_demux_stream4;

  localparam int WIDTH = 2;
  localparam int CNTW  = 8;
  localparam int CMAX  = (1 << CNTW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic             cnt_clr;
  logic [CNTW-1:0]  cnt0, cnt1, cnt2, cnt3;

  int checks = 0;
  int errors = 0;

  // Reference model: each channel is a one-beat slot with a delivered count.
  logic [3:0]       mvalid;
  logic [WIDTH-1:0] mdata [4];
  int               mcnt  [4];

  demux_stream4 #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt_clr(cnt_clr),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  logic       pstall = 1'b0;
  logic [1:0] psel   = 2'd0;
  always @(posedge clk) begin
    if (!rst && pstall && in_valid)
      assert (in_sel === psel)
        else $error("protocol: in_sel changed during stall");
    pstall <= in_valid & ~in_ready & ~rst;
    psel   <= in_sel;
  end

  function automatic logic [WIDTH-1:0] dout(int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      default: return out3;
    endcase
  endfunction

  function automatic int dcnt(int k);
    case (k)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic bit m_ready();
    return !mvalid[in_sel] || out_ready[in_sel];
  endfunction

  task automatic model_reset();
    mvalid = '0;
    for (int k = 0; k < 4; k++) begin
      mdata[k] = '0;
      mcnt[k]  = 0;
    end
  endtask

  // Advance model with the inputs present now, then cross one clock edge.
  task automatic tick();
    bit acc;
    bit del;
    acc = in_valid && m_ready();
    for (int k = 0; k < 4; k++) begin
      del = mvalid[k] && out_ready[k];
      if (cnt_clr) mcnt[k] = 0;
      else if (del && mcnt[k] < CMAX) mcnt[k] = mcnt[k] + 1;
      if (acc && in_sel == 2'(k)) begin
        mvalid[k] = 1'b1;
        mdata[k]  = in_data;
      end else if (del) begin
        mvalid[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, logic [1:0] s, logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_sel = 0; in_data = 0;
    out_ready = 0; cnt_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 4'b0000 || {out0, out1, out2, out3} !== 8'h00 ||
        {cnt0, cnt1, cnt2, cnt3} !== 32'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_init: valid=%b outs=%h cnts=%h rdy=%b want 0/0/0/1",
               out_valid, {out0, out1, out2, out3},
               {cnt0, cnt1, cnt2, cnt3}, in_ready);
    end
    rst = 1'b0;
    #1;
    drive(1, 2'd0, 2'b01); tick();
    drive(1, 2'd1, 2'b10); tick();
    drive(1, 2'd3, 2'b11); tick();
    drive(0, 2'd0, 2'b00);
    checks++;
    if (out_valid !== 4'b1011) begin
      errors++;
      $display("FAIL reset_preload: out_valid=%b want 1011", out_valid);
    end
    out_ready = 4'b0001;
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 4'b0000 || {out0, out1, out2, out3} !== 8'h00 ||
        {cnt0, cnt1, cnt2, cnt3} !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: valid=%b outs=%h cnts=%h want all 0",
               out_valid, {out0, out1, out2, out3}, {cnt0, cnt1, cnt2, cnt3});
    end
    out_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1, 2'd2, 2'b10);
    tick();
    drive(0, 2'd0, 2'b00);
    checks++;
    if (out_valid !== 4'b0100 || out2 !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_accept: valid=%b out2=%b want 0100/10",
               out_valid, out2);
    end
    out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_routing();
    logic [WIDTH-1:0] d [4];
    d[0] = 2'b10; d[1] = 2'b00; d[2] = 2'b01; d[3] = 2'b11;
    cnt_clr = 1; tick(); cnt_clr = 0;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      drive(1, 2'(k), d[k]);
      tick();
      checks++;
      if (dout(k) !== d[k] || out_valid[k] !== 1'b1) begin
        errors++;
        $display("FAIL routing_out%0d: got %b v=%b want %b v=1",
                 k, dout(k), out_valid[k], d[k]);
      end
    end
    drive(0, 2'd0, 2'b00);
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dcnt(k) !== 1) begin
        errors++;
        $display("FAIL routing_cnt%0d: got %0d want 1", k, dcnt(k));
      end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 4'b1011;
    drive(1, 2'd2, 2'b01);
    tick();
    drive(1, 2'd2, 2'b10);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall_ready: in_ready=%b want 0", in_ready);
    end
    repeat (2) tick();
    checks++;
    if (out2 !== 2'b01 || out_valid[2] !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: out2=%b v=%b rdy=%b want 01/1/0",
               out2, out_valid[2], in_ready);
    end
    out_ready = 4'b1111;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    drive(0, 2'd0, 2'b00);
    checks++;
    if (out2 !== 2'b10 || out_valid[2] !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_beat: out2=%b v=%b want 10/1",
               out2, out_valid[2]);
    end
    tick();
  endtask

  task automatic test_independence();
    out_ready = 4'b0000;
    drive(1, 2'd1, 2'b01);
    tick();
    drive(1, 2'd0, 2'b11);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL indep_ready: in_ready=%b want 1", in_ready);
    end
    tick();
    drive(0, 2'd0, 2'b00);
    checks++;
    if (out0 !== 2'b11 || out1 !== 2'b01 || out_valid[1:0] !== 2'b11) begin
      errors++;
      $display("FAIL indep_data: out0=%b out1=%b v=%b want 11/01/11",
               out0, out1, out_valid[1:0]);
    end
    out_ready = 4'b1111;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    out_ready = 4'b1111;
    cnt_clr = 1; tick(); cnt_clr = 0;
    for (int i = 0; i < 4; i++) begin
      d = 2'(i);
      drive(1, 2'd3, d);
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d: in_ready=%b want 1", i, in_ready);
      end
      tick();
      checks++;
      if (out3 !== d || out_valid[3] !== 1'b1) begin
        errors++;
        $display("FAIL b2b_out3_%0d: got %b v=%b want %b v=1",
                 i, out3, out_valid[3], d);
      end
    end
    drive(0, 2'd0, 2'b00);
    tick();
    checks++;
    if (cnt3 !== 8'd4) begin
      errors++;
      $display("FAIL b2b_cnt3: got %0d want 4", cnt3);
    end
  endtask

  task automatic test_counter();
    out_ready = 4'b1111;
    cnt_clr = 1; tick(); cnt_clr = 0;
    for (int i = 0; i < 300; i++) begin
      drive(1, 2'd0, 2'($urandom));
      tick();
    end
    drive(0, 2'd0, 2'b00);
    tick();
    checks++;
    if (cnt0 !== 8'd255) begin
      errors++;
      $display("FAIL cnt_saturate: cnt0=%0d want 255", cnt0);
    end
    drive(1, 2'd0, 2'b01);
    tick();
    drive(0, 2'd0, 2'b00);
    cnt_clr = 1;
    tick();
    cnt_clr = 0;
    checks++;
    if (cnt0 !== 8'd0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL cnt_clr_priority: cnt0=%0d v=%b want 0/0",
               cnt0, out_valid[0]);
    end
  endtask

  task automatic test_random();
    bit stalled;
    int bad;
    stalled = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom);
        in_data  = 2'($urandom);
      end
      out_ready = 4'($urandom);
      cnt_clr   = ($urandom_range(0, 199) == 0);
      #1;
      bad = 0;
      checks++;
      if (in_ready !== m_ready()) begin
        errors++; bad++;
        $display("FAIL rand_ready @%0d: got %b want %b", i, in_ready, m_ready());
      end
      checks++;
      if (out_valid !== mvalid) begin
        errors++; bad++;
        $display("FAIL rand_valid @%0d: got %b want %b", i, out_valid, mvalid);
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (dout(k) !== mdata[k] || dcnt(k) !== mcnt[k]) begin
          errors++; bad++;
          $display("FAIL rand_ch%0d @%0d: data=%b cnt=%0d want %b/%0d",
                   k, i, dout(k), dcnt(k), mdata[k], mcnt[k]);
        end
      end
      if (bad != 0) break;
      stalled = in_valid && !m_ready();
      tick();
    end
    in_valid = 0; cnt_clr = 0;
  endtask

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_independence();
    test_back_to_back();
    test_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
